// File: rtl/sort_gate_dispatch.sv
// Bin-code dispatcher: queues sorter codes and drives one timed, one-hot gate
// per code with a settle gap between windows; code 0 is counted as a reject.
module sort_gate_dispatch #(
    parameter int OPEN_CYCLES   = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [2:0] code,
    output logic       code_ready,
    output logic [6:0] gate,
    output logic [2:0] active_code,
    output logic       busy,
    output logic       done,
    output logic       reject,
    output logic [7:0] reject_cnt,
    output logic [7:0] dispatch_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_OPEN   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam logic [7:0] OPEN_LOAD   = 8'(OPEN_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [AW:0] FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic [1:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [6:0] gate_q, gate_d;
    logic [2:0] active_q, active_d;
    logic [7:0] disp_q, disp_d;
    logic       reject_q, reject_d;
    logic [7:0] rej_cnt_q, rej_cnt_d;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       xfer0;
    logic [2:0] head;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    assign code_ready = !full;
    assign xfer0 = code_valid && code_ready && (code == 3'd0);
    assign push  = code_valid && code_ready && (code != 3'd0);
    assign pop   = (state_q == S_IDLE) && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        gate_d   = gate_q;
        active_d = active_q;
        disp_d   = disp_q;
        unique case (state_q)
            S_IDLE: begin
                gate_d = 7'd0;
                if (!empty) begin
                    gate_d   = 7'd1 << (head - 3'd1);
                    active_d = head;
                    timer_d  = OPEN_LOAD;
                    state_d  = S_OPEN;
                end
            end
            S_OPEN: begin
                if (timer_q == 8'd0) begin
                    gate_d  = 7'd0;
                    timer_d = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            S_SETTLE: begin
                gate_d = 7'd0;
                if (timer_q == 8'd0) begin
                    state_d  = S_IDLE;
                    disp_d   = disp_q + 8'd1;
                    active_d = 3'd0;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                gate_d   = 7'd0;
                active_d = 3'd0;
                timer_d  = 8'd0;
            end
        endcase
    end

    // reject count saturates so a flood of empty slots cannot alias to zero
    assign reject_d  = xfer0;
    assign rej_cnt_d = (xfer0 && rej_cnt_q != 8'hff) ? rej_cnt_q + 8'd1
                                                    : rej_cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            timer_q   <= 8'd0;
            gate_q    <= 7'd0;
            active_q  <= 3'd0;
            disp_q    <= 8'd0;
            reject_q  <= 1'b0;
            rej_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            gate_q    <= gate_d;
            active_q  <= active_d;
            disp_q    <= disp_d;
            reject_q  <= reject_d;
            rej_cnt_q <= rej_cnt_d;
        end
    end

    assign gate         = gate_q;
    assign active_code  = active_q;
    assign busy         = (state_q != S_IDLE) || !empty;
    assign done         = (state_q == S_SETTLE) && (timer_q == 8'd0);
    assign reject       = reject_q;
    assign reject_cnt   = rej_cnt_q;
    assign dispatch_cnt = disp_q;

endmodule
